// File: rtl/multi_player_match_game.sv
// N-player timed sequence-matching game core: LFSR target, per-round countdown, first correct guesser scores.
// Optional build define LOCKOUT_EN: a wrong guess locks that player out for the rest of the round.
module multi_player_match_game #(
    parameter int          NUM_PLAYERS  = 4,
    parameter int          DATA_W       = 4,
    parameter int          SCORE_W      = 4,
    parameter int          ROUND_CYCLES = 1000,
    parameter int          NUM_ROUNDS   = 9,
    parameter int          WIN_SCORE    = 5,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    localparam int         TL_W         = $clog2(ROUND_CYCLES)
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Start,
    input  logic [NUM_PLAYERS*DATA_W-1:0]  Guess,
    input  logic [NUM_PLAYERS-1:0]         GuessVld,
    output logic [DATA_W-1:0]              Target,
    output logic [NUM_PLAYERS*SCORE_W-1:0] Scores,
    output logic [7:0]                     RoundCnt,
    output logic [TL_W-1:0]                TimeLeft,
    output logic                           Busy,
    output logic                           RoundPt,
    output logic [2:0]                     RoundPtIdx,
    output logic [2:0]                     Winner,
    output logic                           WinVld,
    output logic                           Tie,
    output logic [2:0]                     State
);

    // Handshake: Start and GuessVld are single-cycle strobes with no backpressure; a
    // strobe is consumed on the edge it is sampled in an accepting state, otherwise dropped.
    // RoundPt is a one-cycle strobe qualifying RoundPtIdx; WinVld is a level qualifying Winner/Tie.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_SCORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]            lfsr;
    logic [NUM_PLAYERS-1:0] eq;
    logic [NUM_PLAYERS-1:0] vld_eff;
    logic [NUM_PLAYERS-1:0] match;
    logic                   all_locked;
    logic                   hit;
    logic [2:0]             hit_idx;
    logic [SCORE_W-1:0]     score [NUM_PLAYERS];
    logic [SCORE_W-1:0]     max_score;
    logic [2:0]             max_idx;
    logic [3:0]             max_cnt;
    logic                   game_end;

    // Fibonacci LFSR, taps 16,14,13,11; free-running outside reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

`ifdef LOCKOUT_EN
    logic [NUM_PLAYERS-1:0] locked;

    always_ff @(posedge Clk) begin
        if (Rst || state == S_LOAD) begin
            locked <= '0;
        end else if (state == S_ROUND) begin
            locked <= locked | (vld_eff & ~eq);
        end
    end

    assign vld_eff    = GuessVld & ~locked;
    assign all_locked = &locked;
`else
    assign vld_eff    = GuessVld;
    assign all_locked = 1'b0;
`endif

    always_comb begin
        eq = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            eq[i] = (Guess[i*DATA_W +: DATA_W] == Target);
        end
    end

    assign match = (state == S_ROUND) ? (vld_eff & eq) : '0;

    // Scan from the top so the lowest matching index is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_comb begin
        max_score = score[0];
        max_idx   = '0;
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (score[i] > max_score) begin
                max_score = score[i];
                max_idx   = 3'(i);
            end
        end
        max_cnt = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (score[i] == max_score) begin
                max_cnt = max_cnt + 4'd1;
            end
        end
    end

    assign game_end = (max_score >= SCORE_W'(WIN_SCORE)) || (RoundCnt == 8'(NUM_ROUNDS));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_ROUND;
            end
            S_ROUND: begin
                if (hit || TimeLeft == '0 || all_locked) begin
                    state_next = S_SCORE;
                end
            end
            S_SCORE: begin
                state_next = game_end ? S_DONE : S_LOAD;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        Busy  = (state == S_LOAD) || (state == S_ROUND) || (state == S_SCORE);
        State = state;
    end

    always_comb begin
        Scores = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            Scores[i*SCORE_W +: SCORE_W] = score[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Target     <= '0;
            RoundCnt   <= '0;
            TimeLeft   <= '0;
            RoundPt    <= 1'b0;
            RoundPtIdx <= '0;
            Winner     <= '0;
            WinVld     <= 1'b0;
            Tie        <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score[i] <= '0;
            end
        end else begin
            RoundPt    <= 1'b0;
            RoundPtIdx <= '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        RoundCnt <= '0;
                        Winner   <= '0;
                        WinVld   <= 1'b0;
                        Tie      <= 1'b0;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            score[i] <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    Target   <= lfsr[DATA_W-1:0];
                    TimeLeft <= TL_W'(ROUND_CYCLES - 1);
                    RoundCnt <= RoundCnt + 8'd1;
                end
                S_ROUND: begin
                    if (hit) begin
                        RoundPt    <= 1'b1;
                        RoundPtIdx <= hit_idx;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (hit_idx == 3'(i) && score[i] != '1) begin
                                score[i] <= score[i] + 1'b1;
                            end
                        end
                    end else if (TimeLeft != '0 && !all_locked) begin
                        TimeLeft <= TimeLeft - 1'b1;
                    end
                end
                S_SCORE: begin
                    if (game_end) begin
                        WinVld <= 1'b1;
                        Winner <= max_idx;
                        Tie    <= (max_cnt > 4'd1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_player_match_game.sv
// Scoreboard bench for multi_player_match_game: 3 players, 10-cycle rounds, 3 rounds, win at 2.
// Build with LOCKOUT_EN defined to exercise the lockout variant.
module tb_multi_player_match_game;
    localparam int          NP   = 3;
    localparam int          DW   = 4;
    localparam int          SW   = 4;
    localparam int          RC   = 10;
    localparam int          NR   = 3;
    localparam int          WS   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              Start = 1'b0;
    logic [NP*DW-1:0]  Guess = '0;
    logic [NP-1:0]     GuessVld = '0;
    logic [DW-1:0]     Target;
    logic [NP*SW-1:0]  Scores;
    logic [7:0]        RoundCnt;
    logic [3:0]        TimeLeft;
    logic              Busy;
    logic              RoundPt;
    logic [2:0]        RoundPtIdx;
    logic [2:0]        Winner;
    logic              WinVld;
    logic              Tie;
    logic [2:0]        State;

    always #5 Clk = ~Clk;

    multi_player_match_game #(
        .NUM_PLAYERS(NP), .DATA_W(DW), .SCORE_W(SW), .ROUND_CYCLES(RC),
        .NUM_ROUNDS(NR), .WIN_SCORE(WS), .LFSR_SEED(SEED)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Guess(Guess), .GuessVld(GuessVld),
        .Target(Target), .Scores(Scores), .RoundCnt(RoundCnt), .TimeLeft(TimeLeft),
        .Busy(Busy), .RoundPt(RoundPt), .RoundPtIdx(RoundPtIdx), .Winner(Winner),
        .WinVld(WinVld), .Tie(Tie), .State(State)
    );

    int checks = 0;
    int errors = 0;

    // exp_q: {pt, idx[2:0], scores[11:0], round_cnt[7:0]}; win_q: {winner[2:0], tie, scores[11:0]}
    logic [23:0] exp_q[$];
    logic [15:0] win_q[$];

    logic [15:0] lfsr_m;
    int          sc_m[NP];
    int          rounds_m;
    logic        win_prev = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [11:0] pack_scores();
        return {4'(sc_m[2]), 4'(sc_m[1]), 4'(sc_m[0])};
    endfunction

    always @(posedge Clk) begin
        if (Rst) lfsr_m <= SEED;
        else     lfsr_m <= lfsr_step(lfsr_m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop one record per SCORE cycle and one per DONE entry
    always @(negedge Clk) begin
        logic [23:0] e;
        logic [15:0] w;
        if (!Rst && State == 3'd3) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_round_end: got round end, expected none");
            end else begin
                e = exp_q.pop_front();
                check("round_pt", 32'(RoundPt), 32'(e[23]));
                if (e[23]) check("round_pt_idx", 32'(RoundPtIdx), 32'(e[22:20]));
                check("scores_after_round", 32'(Scores), 32'(e[19:8]));
                check("round_cnt_at_score", 32'(RoundCnt), 32'(e[7:0]));
            end
        end
        if (!Rst && WinVld && !win_prev) begin
            if (win_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got WinVld, expected none");
            end else begin
                w = win_q.pop_front();
                check("winner", 32'(Winner), 32'(w[15:13]));
                check("tie", 32'(Tie), 32'(w[12]));
                check("scores_at_done", 32'(Scores), 32'(w[11:0]));
                check("busy_in_done", 32'(Busy), 32'd0);
            end
        end
        win_prev <= Rst ? 1'b0 : WinVld;
    end

    task automatic push_end_if_over();
        int mx;
        int mi;
        int cnt;
        mx = sc_m[0];
        mi = 0;
        for (int p = 1; p < NP; p++) if (sc_m[p] > mx) begin mx = sc_m[p]; mi = p; end
        cnt = 0;
        for (int p = 0; p < NP; p++) if (sc_m[p] == mx) cnt++;
        if (mx >= WS || rounds_m == NR) win_q.push_back({3'(mi), cnt > 1, pack_scores()});
    endtask

    // Called at a negedge in IDLE or DONE; returns at the negedge inside LOAD
    task automatic start_game();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int p = 0; p < NP; p++) sc_m[p] = 0;
        rounds_m = 0;
    endtask

    task automatic drive_guess(input logic [2:0] v, input logic [2:0] ok, input logic [3:0] tgt);
        for (int p = 0; p < NP; p++) Guess[p*DW +: DW] = ok[p] ? tgt : (tgt ^ 4'h5);
        GuessVld = v;
    endtask

    // Starts at the negedge inside LOAD; guesses issued in ROUND cycle j (TimeLeft = RC-1-j).
    // Ends at the negedge after SCORE (next LOAD or DONE).
    task automatic do_round(input int j1, input logic [2:0] v1, input logic [2:0] ok1,
                            input int j2, input logic [2:0] v2, input logic [2:0] ok2,
                            input int exp_idx, input int exp_end);
        logic [3:0] tgt;
        tgt = lfsr_m[3:0];
        rounds_m++;
        if (exp_idx >= 0 && sc_m[exp_idx] < 15) sc_m[exp_idx]++;
        exp_q.push_back({exp_idx >= 0, 3'(exp_idx >= 0 ? exp_idx : 0), pack_scores(), 8'(rounds_m)});
        push_end_if_over();
        for (int n = 0; n <= exp_end + 1; n++) begin
            @(negedge Clk);
            GuessVld = '0;
            Guess    = '0;
            if (n == 0) begin
                check("target", 32'(Target), 32'(tgt));
                check("round_cnt", 32'(RoundCnt), 32'(rounds_m));
                check("busy_in_round", 32'(Busy), 32'd1);
                check("time_left_start", 32'(TimeLeft), 32'(RC - 1));
            end
            if (n == j1) drive_guess(v1, ok1, tgt);
            if (n == j2) drive_guess(v2, ok2, tgt);
            if (n == j1 || n == j2) check("time_left_at_guess", 32'(TimeLeft), 32'(RC - 1 - n));
        end
        @(negedge Clk);
        GuessVld = '0;
        check("round_pt_pulse_low", 32'(RoundPt), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("reset_scores", 32'(Scores), 32'd0);
        check("reset_misc", 32'({Target, RoundCnt, TimeLeft, Busy, RoundPt, RoundPtIdx,
                                 Winner, WinVld, Tie, State}), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        check("idle_state", 32'(State), 32'd0);

        // Game 1: p2 at TimeLeft=5, p0+p1 together, then expiry -> tie at round limit
        start_game();
        do_round(4, 3'b100, 3'b100, -1, 3'b000, 3'b000, 2, 4);
        do_round(2, 3'b011, 3'b011, -1, 3'b000, 3'b000, 0, 2);
        do_round(-1, 3'b000, 3'b000, -1, 3'b000, 3'b000, -1, 9);
        check("done_state_g1", 32'(State), 32'd4);

        // Game 2: restart from DONE; p0 wrong, p1 right at TimeLeft=0; p1 wins early
        start_game();
        do_round(1, 3'b001, 3'b000, 9, 3'b010, 3'b010, 1, 9);
        do_round(0, 3'b110, 3'b010, -1, 3'b000, 3'b000, 1, 0);
        check("done_state_g2", 32'(State), 32'd4);

        // Game 3: p0 wrong then right; all players wrong; expiry
        start_game();
`ifdef LOCKOUT_EN
        do_round(1, 3'b001, 3'b000, 3, 3'b001, 3'b001, -1, 9);
        do_round(0, 3'b111, 3'b000, -1, 3'b000, 3'b000, -1, 1);
`else
        do_round(1, 3'b001, 3'b000, 3, 3'b001, 3'b001, 0, 3);
        do_round(0, 3'b111, 3'b000, -1, 3'b000, 3'b000, -1, 9);
`endif
        do_round(-1, 3'b000, 3'b000, -1, 3'b000, 3'b000, -1, 9);
        check("done_state_g3", 32'(State), 32'd4);

        // Game 4: reset in the middle of a round
        start_game();
        repeat (4) @(negedge Clk);
        check("time_left_mid", 32'(TimeLeft), 32'd6);
        Rst = 1'b1;
        @(negedge Clk);
        check("midrst_scores", 32'(Scores), 32'd0);
        check("midrst_misc", 32'({Target, RoundCnt, TimeLeft, Busy, RoundPt, RoundPtIdx,
                                  Winner, WinVld, Tie, State}), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // Game 5: normal play after reset; p1 wins two rounds
        start_game();
        do_round(5, 3'b010, 3'b010, -1, 3'b000, 3'b000, 1, 5);
        do_round(0, 3'b010, 3'b010, -1, 3'b000, 3'b000, 1, 0);
        check("done_state_g5", 32'(State), 32'd4);
        check("win_vld_held", 32'(WinVld), 32'd1);

        repeat (2) @(negedge Clk);
        check("queues_drained", 32'(exp_q.size() + win_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
